md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_pkg.sv | 37 +++
 rtl/md_ctrl_if.sv | 33 +++
 rtl/md_div_step.sv | 27 ++
 rtl/md_ctrl.sv | 150 +++++++++++++++
 tb/tb_md_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Package  : md_ctrl_pkg
// Summary  : Shared opcode bit positions, FSM encodings and helpers for the
//            multiply/divide/move unit.
// Revision : 1.0 - initial release
//==============================================================================
package md_ctrl_pkg;

    localparam int c_OP_W = 6;

    // Bit positions inside the one-hot md_op vector {MULT,MULTU,DIV,DIVU,MTHI,MTLO}
    localparam int c_OP_MULT  = 5;
    localparam int c_OP_MULTU = 4;
    localparam int c_OP_DIV   = 3;
    localparam int c_OP_DIVU  = 2;
    localparam int c_OP_MTHI  = 1;
    localparam int c_OP_MTLO  = 0;

    localparam int          c_ST_W    = 2;
    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_MUL  = 2'd1;
    localparam logic [1:0]  c_ST_DIV  = 2'd2;
    localparam logic [1:0]  c_ST_DONE = 2'd3;

    localparam logic [5:0]  c_DIV_LAST = 6'd31;

    function automatic logic is_onehot(input logic [c_OP_W-1:0] v);
        return (v != '0) && ((v & (v - 6'd1)) == '0);
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface : md_ctrl_if
// Summary   : EX-stage request/readback bundle between pipeline and md_ctrl.
// Revision  : 1.0 - initial release
//==============================================================================
interface md_ctrl_if;
    import md_ctrl_pkg::*;

    logic              md_valid;
    logic [c_OP_W-1:0] md_op;
    logic [31:0]       md_src1;
    logic [31:0]       md_src2;
    logic              md_rd_req;
    logic              md_rd_hi;
    logic              ex_flush;
    logic [31:0]       MD_data;
    logic              md_ready;
    logic              md_busy;
    logic              md_stall;

    modport master (
        output md_valid, md_op, md_src1, md_src2, md_rd_req, md_rd_hi, ex_flush,
        input  MD_data, md_ready, md_busy, md_stall
    );

    modport slave (
        input  md_valid, md_op, md_src1, md_src2, md_rd_req, md_rd_hi, ex_flush,
        output MD_data, md_ready, md_busy, md_stall
    );

endinterface
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
//==============================================================================
// Module   : md_div_step
// Summary  : One restoring-division iteration on a {remainder, quotient} pair.
// Revision : 1.0 - initial release
//==============================================================================
module md_div_step (
    input  wire logic [63:0] i_pr,
    input  wire logic [31:0] i_divisor,
    output logic      [63:0] o_pr
);

    logic [32:0] w_top;
    logic        w_ge;
    logic [31:0] w_sub;

    // Remainder stays below the divisor, so the shifted value needs 33 bits
    // but the difference always fits back into 32.
    assign w_top = i_pr[63:31];
    assign w_ge  = (w_top >= {1'b0, i_divisor});
    assign w_sub = w_top[31:0] - i_divisor;

    assign o_pr = w_ge ? {w_sub, i_pr[30:0], 1'b1}
                       : {i_pr[62:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : md_ctrl
// Summary  : HI/LO multiply/divide unit: single-cycle MULT, 32-step restoring
//            DIV, MTHI/MTLO writes and pipeline stall generation.
// Revision : 1.0 - initial release
//==============================================================================
module md_ctrl
    import md_ctrl_pkg::*;
(
    input  wire logic clk,
    input  wire logic resetn,
    md_ctrl_if.slave  bus
);

    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [31:0]       r_hi, w_hi_nxt;
    logic [31:0]       r_lo, w_lo_nxt;
    logic [5:0]        r_cnt, w_cnt_nxt;
    logic [31:0]       r_op_a, w_op_a_nxt;
    logic [31:0]       r_op_b, w_op_b_nxt;
    logic [63:0]       r_pr, w_pr_nxt;
    logic              r_sign1, w_sign1_nxt;
    logic              r_sign2, w_sign2_nxt;
    logic              r_signed, w_signed_nxt;

    logic              w_req_ok;
    logic              w_div_s1;
    logic              w_div_s2;
    logic [63:0]       w_mul_a;
    logic [63:0]       w_mul_b;
    logic [63:0]       w_prod;
    logic [63:0]       w_pr_step;

    assign w_req_ok = bus.md_valid && is_onehot(bus.md_op);
    assign w_div_s1 = bus.md_op[c_OP_DIV] & bus.md_src1[31];
    assign w_div_s2 = bus.md_op[c_OP_DIV] & bus.md_src2[31];

    // Sign-extending to 64 bits makes the low 64 product bits correct for
    // both signed and unsigned operands.
    assign w_mul_a = {{32{r_signed & r_op_a[31]}}, r_op_a};
    assign w_mul_b = {{32{r_signed & r_op_b[31]}}, r_op_b};
    assign w_prod  = w_mul_a * w_mul_b;

    md_div_step u_div_step (
        .i_pr      (r_pr),
        .i_divisor (r_op_b),
        .o_pr      (w_pr_step)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_ST_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_pr     <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op_a   <= w_op_a_nxt;
            r_op_b   <= w_op_b_nxt;
            r_pr     <= w_pr_nxt;
            r_sign1  <= w_sign1_nxt;
            r_sign2  <= w_sign2_nxt;
            r_signed <= w_signed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_cnt_nxt    = r_cnt;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_pr_nxt     = r_pr;
        w_sign1_nxt  = r_sign1;
        w_sign2_nxt  = r_sign2;
        w_signed_nxt = r_signed;

        case (r_state)
            c_ST_IDLE: begin
                if (w_req_ok) begin
                    if (bus.md_op[c_OP_MTHI]) begin
                        w_hi_nxt = bus.md_src1;
                    end else if (bus.md_op[c_OP_MTLO]) begin
                        w_lo_nxt = bus.md_src1;
                    end else if (bus.md_op[c_OP_MULT] || bus.md_op[c_OP_MULTU]) begin
                        w_op_a_nxt   = bus.md_src1;
                        w_op_b_nxt   = bus.md_src2;
                        w_signed_nxt = bus.md_op[c_OP_MULT];
                        w_state_nxt  = c_ST_MUL;
                    end else begin
                        w_signed_nxt = bus.md_op[c_OP_DIV];
                        w_sign1_nxt  = w_div_s1;
                        w_sign2_nxt  = w_div_s2;
                        w_pr_nxt     = {32'd0, cond_neg(bus.md_src1, w_div_s1)};
                        w_op_b_nxt   = cond_neg(bus.md_src2, w_div_s2);
                        w_cnt_nxt    = '0;
                        w_state_nxt  = c_ST_DIV;
                    end
                end
            end
            c_ST_MUL: begin
                w_hi_nxt    = w_prod[63:32];
                w_lo_nxt    = w_prod[31:0];
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_DIV: begin
                w_pr_nxt  = w_pr_step;
                w_cnt_nxt = r_cnt + 6'd1;
                if (r_cnt == c_DIV_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // A zero divisor leaves the dividend in the remainder half, so
                // only the quotient needs forcing to all ones.
                w_lo_nxt    = (r_op_b == 32'd0) ? 32'hFFFF_FFFF
                                                : cond_neg(r_pr[31:0], r_sign1 ^ r_sign2);
                w_hi_nxt    = cond_neg(r_pr[63:32], r_sign1);
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (bus.ex_flush) begin
            w_state_nxt = c_ST_IDLE;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end
    end

    assign bus.md_ready = (r_state == c_ST_IDLE);
    assign bus.md_busy  = (r_state != c_ST_IDLE);
    assign bus.md_stall = bus.md_busy && (bus.md_valid || bus.md_rd_req);
    assign bus.MD_data  = bus.md_rd_hi ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_md_ctrl
// Summary  : Scoreboard-based self-checking bench for md_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    md_ctrl_if bus();

    md_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    function automatic logic [5:0] opbit(input int idx);
        logic [5:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Reference model: updates the bench HI/LO copy and queues the expectation.
    task automatic model_push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input string name);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p, ua, ub;
        int          ia, ib;
        e.hi = m_hi;
        e.lo = m_lo;
        e.name = name;
        if (op[c_OP_MULT]) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op[c_OP_MULTU]) begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            p  = ua * ub;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (op[c_OP_DIV] || op[c_OP_DIVU]) begin
            if (b == 32'd0) begin
                e.lo = 32'hFFFF_FFFF;
                e.hi = a;
            end else if (op[c_OP_DIV] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'd0;
            end else if (op[c_OP_DIV]) begin
                ia = a;
                ib = b;
                e.lo = ia / ib;
                e.hi = ia % ib;
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end else if (op[c_OP_MTHI]) begin
            e.hi = a;
        end else if (op[c_OP_MTLO]) begin
            e.lo = a;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        exp_q.push_back(e);
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.md_rd_hi = 1'b1;
        #1 h = bus.MD_data;
        bus.md_rd_hi = 1'b0;
        #1 l = bus.MD_data;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, output int edges);
        model_push(op, a, b, name);
        bus.md_valid = 1'b1;
        bus.md_op    = op;
        bus.md_src1  = a;
        bus.md_src2  = b;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        edges = 1;
        while (bus.md_ready !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        resetn        = 1'b0;
        bus.md_valid  = 1'b0;
        bus.md_op     = '0;
        bus.md_src1   = '0;
        bus.md_src2   = '0;
        bus.md_rd_req = 1'b1;
        bus.md_rd_hi  = 1'b0;
        bus.ex_flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.md_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.md_ready); else n_pass++;
        n_chk++; if (bus.md_busy !== 1'b0)  $display("FAIL reset_busy: got %b expected 0", bus.md_busy); else n_pass++;
        n_chk++; if (bus.md_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.md_stall); else n_pass++;
        read_hilo(h, l);
        n_chk++; if (h !== 32'd0) $display("FAIL reset_hi: got %h expected 0", h); else n_pass++;
        n_chk++; if (l !== 32'd0) $display("FAIL reset_lo: got %h expected 0", l); else n_pass++;
        bus.md_rd_req = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (bus.md_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", bus.md_ready); else n_pass++;
    endtask

    task automatic test_mult();
        logic [5:0]  ops[4];
        logic [31:0] as[4], bs[4];
        logic [31:0] h, l;
        exp_t        e;
        int          edges;
        ops = '{opbit(c_OP_MULT), opbit(c_OP_MULTU), opbit(c_OP_MULT), opbit(c_OP_MULTU)};
        as  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, $urandom, $urandom};
        bs  = '{32'h0000_0003, 32'h0000_0003, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], $sformatf("mult%0d", i), edges);
            e = exp_q.pop_front();
            read_hilo(h, l);
            n_chk++; if (edges !== 2) $display("FAIL %s_latency: got %0d edges expected 2", e.name, edges); else n_pass++;
            n_chk++; if (h !== e.hi) $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); else n_pass++;
            n_chk++; if (l !== e.lo) $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); else n_pass++;
        end
    endtask

    task automatic test_div();
        logic [5:0]  ops[8];
        logic [31:0] as[8], bs[8];
        logic [31:0] h, l;
        exp_t        e;
        int          edges;
        ops = '{opbit(c_OP_DIV), opbit(c_OP_DIVU), opbit(c_OP_DIVU), opbit(c_OP_DIV),
                opbit(c_OP_DIV), opbit(c_OP_DIV), opbit(c_OP_DIVU), opbit(c_OP_DIV)};
        as  = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000,
                32'hFFFF_FFF9, $urandom, $urandom, $urandom};
        bs  = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF,
                32'd0, $urandom_range(1, 1000), $urandom_range(1, 65535), 32'hFFFF_FFFF - $urandom_range(0, 500)};
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], $sformatf("div%0d", i), edges);
            e = exp_q.pop_front();
            read_hilo(h, l);
            n_chk++; if (edges !== 34) $display("FAIL %s_latency: got %0d edges expected 34", e.name, edges); else n_pass++;
            n_chk++; if (h !== e.hi) $display("FAIL %s_hi: got %h expected %h", e.name, h, e.hi); else n_pass++;
            n_chk++; if (l !== e.lo) $display("FAIL %s_lo: got %h expected %h", e.name, l, e.lo); else n_pass++;
        end
    endtask

    task automatic test_move();
        logic [31:0] h, l;
        exp_t        e;
        int          edges;
        run_op(opbit(c_OP_MTHI), 32'hCAFE_F00D, 32'd0, "mthi", edges);
        e = exp_q.pop_front();
        n_chk++; if (edges !== 1) $display("FAIL mthi_no_state_change: got %0d edges expected 1", edges); else n_pass++;
        run_op(opbit(c_OP_MTLO), 32'h0BAD_BEEF, 32'd0, "mtlo", edges);
        e = exp_q.pop_front();
        n_chk++; if (bus.md_busy !== 1'b0) $display("FAIL mtlo_busy: got %b expected 0", bus.md_busy); else n_pass++;
        read_hilo(h, l);
        n_chk++; if (h !== e.hi) $display("FAIL move_hi: got %h expected %h", h, e.hi); else n_pass++;
        n_chk++; if (l !== e.lo) $display("FAIL move_lo: got %h expected %h", l, e.lo); else n_pass++;
    endtask

    task automatic test_invalid_op();
        logic [5:0]  bad_ops[2];
        logic [31:0] h, l;
        bad_ops = '{6'b000000, 6'b110000};
        for (int i = 0; i < 2; i++) begin
            bus.md_valid = 1'b1;
            bus.md_op    = bad_ops[i];
            bus.md_src1  = 32'h1111_2222;
            bus.md_src2  = 32'd3;
            @(posedge clk); #1;
            bus.md_valid = 1'b0;
            n_chk++; if (bus.md_ready !== 1'b1) $display("FAIL invalid%0d_ready: got %b expected 1", i, bus.md_ready); else n_pass++;
            read_hilo(h, l);
            n_chk++; if ({h, l} !== {m_hi, m_lo}) $display("FAIL invalid%0d_hilo: got %h expected %h", i, {h, l}, {m_hi, m_lo}); else n_pass++;
        end
    endtask

    task automatic test_stall_mfhi();
        exp_t e;
        int   edges, bad;
        model_push(opbit(c_OP_DIV), 32'hFFFF_FF9C, 32'd7, "div_mfhi");
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_DIV);
        bus.md_src1  = 32'hFFFF_FF9C;
        bus.md_src2  = 32'd7;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        edges = 1;
        repeat (2) begin
            @(posedge clk); #1;
            edges++;
        end
        bus.md_rd_req = 1'b1;
        bus.md_rd_hi  = 1'b1;
        bad = 0;
        while (bus.md_ready !== 1'b1 && edges < 100) begin
            #1 if (bus.md_stall !== 1'b1) bad++;
            @(posedge clk); #1;
            edges++;
        end
        e = exp_q.pop_front();
        n_chk++; if (bad !== 0) $display("FAIL mfhi_stall_held: got %0d unstalled cycles expected 0", bad); else n_pass++;
        n_chk++; if (edges !== 34) $display("FAIL mfhi_latency: got %0d edges expected 34", edges); else n_pass++;
        n_chk++; if (bus.md_stall !== 1'b0) $display("FAIL mfhi_stall_release: got %b expected 0", bus.md_stall); else n_pass++;
        n_chk++; if (bus.MD_data !== e.hi) $display("FAIL mfhi_data: got %h expected %h", bus.MD_data, e.hi); else n_pass++;
        bus.md_rd_req = 1'b0;
        bus.md_rd_hi  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        exp_t        e;
        int          cyc;
        model_push(opbit(c_OP_DIVU), 32'd1000, 32'd10, "b2b_divu");
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_DIVU);
        bus.md_src1  = 32'd1000;
        bus.md_src2  = 32'd10;
        @(posedge clk); #1;
        model_push(opbit(c_OP_MULTU), 32'd7, 32'd6, "b2b_multu");
        bus.md_op   = opbit(c_OP_MULTU);
        bus.md_src1 = 32'd7;
        bus.md_src2 = 32'd6;
        n_chk++; if (bus.md_stall !== 1'b1) $display("FAIL b2b_stall: got %b expected 1", bus.md_stall); else n_pass++;
        cyc = 0;
        while (bus.md_stall === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = exp_q.pop_front();
        read_hilo(h, l);
        n_chk++; if ({h, l} !== {e.hi, e.lo}) $display("FAIL %s_hilo: got %h expected %h", e.name, {h, l}, {e.hi, e.lo}); else n_pass++;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        n_chk++; if (bus.md_busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", bus.md_busy); else n_pass++;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        read_hilo(h, l);
        n_chk++; if ({h, l} !== {e.hi, e.lo}) $display("FAIL %s_hilo: got %h expected %h", e.name, {h, l}, {e.hi, e.lo}); else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] h, l;
        exp_t        e;
        int          edges;
        run_op(opbit(c_OP_MTLO), 32'h0000_1234, 32'd0, "flush_mtlo", edges);
        e = exp_q.pop_front();
        // DIV flushed on its 10th cycle
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_DIVU);
        bus.md_src1  = 32'd100;
        bus.md_src2  = 32'd7;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.ex_flush = 1'b0;
        n_chk++; if (bus.md_ready !== 1'b1) $display("FAIL flush_div_idle: got %b expected 1", bus.md_ready); else n_pass++;
        read_hilo(h, l);
        n_chk++; if (l !== 32'h0000_1234) $display("FAIL flush_div_lo: got %h expected 00001234", l); else n_pass++;
        n_chk++; if (h !== m_hi) $display("FAIL flush_div_hi: got %h expected %h", h, m_hi); else n_pass++;
        // MULT flushed while in MUL
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_MULT);
        bus.md_src1  = 32'd5;
        bus.md_src2  = 32'd5;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.ex_flush = 1'b0;
        read_hilo(h, l);
        n_chk++; if ({h, l} !== {m_hi, m_lo}) $display("FAIL flush_mul_hilo: got %h expected %h", {h, l}, {m_hi, m_lo}); else n_pass++;
        // Request and flush in the same IDLE cycle
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_MTHI);
        bus.md_src1  = 32'hDEAD_0000;
        bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        bus.ex_flush = 1'b0;
        read_hilo(h, l);
        n_chk++; if (h !== m_hi) $display("FAIL flush_idle_hi: got %h expected %h", h, m_hi); else n_pass++;
        // DIV flushed in DONE
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_DIVU);
        bus.md_src1  = 32'd100;
        bus.md_src2  = 32'd7;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        n_chk++; if (bus.md_busy !== 1'b1) $display("FAIL flush_done_busy: got %b expected 1", bus.md_busy); else n_pass++;
        bus.ex_flush = 1'b1;
        @(posedge clk); #1;
        bus.ex_flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        read_hilo(h, l);
        n_chk++; if ({h, l} !== {m_hi, m_lo}) $display("FAIL flush_done_hilo: got %h expected %h", {h, l}, {m_hi, m_lo}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        bus.md_valid = 1'b1;
        bus.md_op    = opbit(c_OP_DIV);
        bus.md_src1  = 32'd100;
        bus.md_src2  = 32'd7;
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_chk++; if (bus.md_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", bus.md_ready); else n_pass++;
        n_chk++; if (bus.md_busy !== 1'b0)  $display("FAIL rstmid_busy: got %b expected 0", bus.md_busy); else n_pass++;
        read_hilo(h, l);
        n_chk++; if ({h, l} !== 64'd0) $display("FAIL rstmid_hilo: got %h expected 0", {h, l}); else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        read_hilo(h, l);
        n_chk++; if ({h, l} !== {m_hi, m_lo}) $display("FAIL rstmid_no_write: got %h expected %h", {h, l}, {m_hi, m_lo}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_invalid_op();
        test_stall_mfhi();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
